alu_pipe: RTL

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe
//
// Two-stage pipelined ALU with a valid/ready handshake on both sides.
// Stage 1 captures the opcode and operands of an accepted request.
// Stage 2 captures the computed result, the flags and the illegal bit.
// With the consumer always ready, the pipeline sustains one operation
// per cycle. When the consumer stalls, results are held stable and are
// never dropped, duplicated or reordered.
//
// Parameters
//   WIDTH        datapath width; a power of two from 4 to 64 (default 8)
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset (empties both stages)
//   in_valid     request present
//   in_ready     request accepted this cycle when in_valid is also high
//   instruction  4-bit opcode:
//                  0 ADD, 1 SUB, 2 NOT B, 3 AND, 4 OR, 5 XOR,
//                  6 SLL A, 7 SRL A, 8 SRA A, 9 SLT, 10 SLTU, 11 PASS A,
//                  12-15 illegal
//   inputA       operand A
//   inputB       operand B (low log2(WIDTH) bits give the shift amount)
//   out_valid    result present
//   out_ready    consumer takes the result this cycle
//   alu_out      result
//   flags        {N, Z, C, V} describing alu_out
//   illegal      result came from an unsupported opcode
//
// Build option
//   ALU_PIPE_SAT_EN  when defined, ADD and SUB saturate on signed
//                    overflow instead of wrapping; V still reports it.
// ---------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       instruction,
    input  logic [WIDTH-1:0] inputA,
    input  logic [WIDTH-1:0] inputB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic [3:0]       flags,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_NOTB = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_SLL  = 4'd6,
        OP_SRL  = 4'd7,
        OP_SRA  = 4'd8,
        OP_SLT  = 4'd9,
        OP_SLTU = 4'd10,
        OP_PASS = 4'd11
    } opcode_e;

    // Stage 1 registers
    logic             r_s1Valid;
    logic [3:0]       r_s1Op;
    logic [WIDTH-1:0] r_s1A;
    logic [WIDTH-1:0] r_s1B;

    // Stage 2 registers (drive the outputs directly)
    logic             r_s2Valid;
    logic [WIDTH-1:0] r_aluOut;
    logic [3:0]       r_flags;
    logic             r_illegal;

    // Handshake and datapath wires
    logic             w_s2Advance;
    logic             w_s1Free;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] w_final;
    logic             w_carry;
    logic             w_ovf;
    logic             w_illegal;
    logic [3:0]       w_flags;

    // Stage 2 can take a new entry when it is empty or its current
    // result is being popped. Stage 1 moves forward under the same
    // condition, so stage 1 is free to accept when it is empty or
    // moving forward. Requests are refused while reset is asserted.
    assign w_s2Advance = !r_s2Valid || out_ready;
    assign w_s1Free    = !r_s1Valid || w_s2Advance;
    assign in_ready    = !reset && w_s1Free;

    assign out_valid = r_s2Valid;
    assign alu_out   = r_aluOut;
    assign flags     = r_flags;
    assign illegal   = r_illegal;

    // Add and subtract one bit wider than the datapath so the top bit
    // is the carry-out (ADD) or the unsigned borrow (SUB).
    assign w_sum   = {1'b0, r_s1A} + {1'b0, r_s1B};
    assign w_diff  = {1'b0, r_s1A} - {1'b0, r_s1B};
    assign w_shamt = r_s1B[SHW-1:0];

    // Raw operation result. Signed overflow for ADD happens when both
    // operands share a sign that the result does not; for SUB when the
    // operand signs differ and the result sign differs from A.
    always_comb begin
        w_result  = '0;
        w_carry   = 1'b0;
        w_ovf     = 1'b0;
        w_illegal = 1'b0;
        case (r_s1Op)
            OP_ADD: begin
                w_result = w_sum[WIDTH-1:0];
                w_carry  = w_sum[WIDTH];
                w_ovf    = (r_s1A[WIDTH-1] == r_s1B[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != r_s1A[WIDTH-1]);
            end
            OP_SUB: begin
                w_result = w_diff[WIDTH-1:0];
                w_carry  = w_diff[WIDTH];
                w_ovf    = (r_s1A[WIDTH-1] != r_s1B[WIDTH-1]) &&
                           (w_diff[WIDTH-1] != r_s1A[WIDTH-1]);
            end
            OP_NOTB: w_result = ~r_s1B;
            OP_AND:  w_result = r_s1A & r_s1B;
            OP_OR:   w_result = r_s1A | r_s1B;
            OP_XOR:  w_result = r_s1A ^ r_s1B;
            OP_SLL:  w_result = r_s1A << w_shamt;
            OP_SRL:  w_result = r_s1A >> w_shamt;
            OP_SRA:  w_result = $signed(r_s1A) >>> w_shamt;
            OP_SLT:  w_result = {{(WIDTH-1){1'b0}},
                                 ($signed(r_s1A) < $signed(r_s1B))};
            OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, (r_s1A < r_s1B)};
            OP_PASS: w_result = r_s1A;
            default: w_illegal = 1'b1;
        endcase
    end

`ifdef ALU_PIPE_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // On overflow, the sign of A tells the direction: a non-negative A
    // can only overflow upwards, a negative A only downwards.
    always_comb begin
        w_final = w_result;
        if (w_ovf && (r_s1Op == OP_ADD || r_s1Op == OP_SUB)) begin
            w_final = r_s1A[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign w_final = w_result;
`endif

    // N and Z come from the final value; illegal opcodes report no flags.
    assign w_flags = w_illegal ? 4'b0000 :
                     {w_final[WIDTH-1], (w_final == '0), w_carry, w_ovf};

    // Stage 1: capture a request whenever the stage is free. A free
    // stage with no request simply becomes empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1Valid <= 1'b0;
            r_s1Op    <= '0;
            r_s1A     <= '0;
            r_s1B     <= '0;
        end else if (w_s1Free) begin
            r_s1Valid <= in_valid;
            if (in_valid) begin
                r_s1Op <= instruction;
                r_s1A  <= inputA;
                r_s1B  <= inputB;
            end
        end
    end

    // Stage 2: load the computed result when it can advance; otherwise
    // hold so a stalled result stays stable until popped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2Valid <= 1'b0;
            r_aluOut  <= '0;
            r_flags   <= '0;
            r_illegal <= 1'b0;
        end else if (w_s2Advance) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_aluOut  <= w_final;
                r_flags   <= w_flags;
                r_illegal <= w_illegal;
            end
        end
    end

endmodule
